// File: rtl/rijndael_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : rijndael_pkg
//  Brief   : Shared types and constants for the sequential SubBytes engine.
//  Revision: 1.0
// ============================================================================
package rijndael_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    localparam logic SBOX_FWD = 1'b0;
    localparam logic SBOX_INV = 1'b1;

    function automatic int statesize(input int nb);
        return 32 * nb;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rijndael_sbox_dual.sv
`default_nettype none
// ============================================================================
//  Module  : rijndael_sbox_dual
//  Brief   : Forward / inverse Rijndael S-box, table based, muxed by inv_i.
//  Revision: 1.0
// ============================================================================
module rijndael_sbox_dual
    import rijndael_pkg::*;
(
    input  logic [7:0] in_byte_i,
    input  logic       inv_i,
    output logic [7:0] out_byte_o
);

    // Entry for input x lives at index 255-x, so the lookup index is ~x.
    localparam logic [255:0][7:0] c_fwd_tbl = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [255:0][7:0] c_inv_tbl = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    logic [7:0] tbl_idx;

    assign tbl_idx    = ~in_byte_i;
    assign out_byte_o = (inv_i == SBOX_INV) ? c_inv_tbl[tbl_idx] : c_fwd_tbl[tbl_idx];

endmodule
`default_nettype wire

// File: rtl/rijndael_subbytes_seq.sv
`default_nettype none
// ============================================================================
//  Module  : rijndael_subbytes_seq
//  Brief   : Multi-cycle SubBytes / InvSubBytes, NSBOX S-boxes time-shared
//            over the state with valid/ready handshakes on both sides.
//  Revision: 1.0
// ============================================================================
module rijndael_subbytes_seq
    import rijndael_pkg::*;
#(
    parameter  int NB        = 4,
    parameter  int NSBOX     = 4,
    localparam int STATESIZE = statesize(NB)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [STATESIZE-1:0] in_state_i,
    input  logic                 in_inv_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [STATESIZE-1:0] out_state_o
);

    localparam int NUMBYTES = 4 * NB;
    localparam int NCHUNK   = NUMBYTES / NSBOX;
    localparam int CW       = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CHUNKW   = 8 * NSBOX;
    localparam int IW       = $clog2(STATESIZE);
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    if (NB != 4 && NB != 6 && NB != 8) begin : g_bad_nb
        $error("rijndael_subbytes_seq: NB must be 4, 6 or 8");
    end

    if ((NUMBYTES % NSBOX) != 0) begin : g_bad_nsbox
        $error("rijndael_subbytes_seq: NSBOX must divide 4*NB");
    end

    fsm_e                 state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [STATESIZE-1:0] work_q, work_d;
    logic                 mode_q, mode_d;

    logic [IW-1:0]        chunk_base;
    logic [CHUNKW-1:0]    chunk_in;
    logic [CHUNKW-1:0]    chunk_out;

    assign in_ready_o  = (state_q == IDLE);
    assign out_valid_o = (state_q == DONE);
    assign out_state_o = work_q;

    // cnt never passes NCHUNK-1, so the selected chunk always lies inside work_q.
    assign chunk_base = IW'(cnt_q) * IW'(CHUNKW);
    assign chunk_in   = work_q[chunk_base +: CHUNKW];

    for (genvar g = 0; g < NSBOX; g++) begin : g_sbox
        rijndael_sbox_dual u_sbox (
            .in_byte_i  (chunk_in[8*g +: 8]),
            .inv_i      (mode_q),
            .out_byte_o (chunk_out[8*g +: 8])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    work_d  = in_state_i;
                    mode_d  = in_inv_i;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d[chunk_base +: CHUNKW] = chunk_out;
                if (cnt_q == LAST_CNT) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            work_q <= '0;
            mode_q <= SBOX_FWD;
        end else begin
            cnt_q  <= cnt_d;
            work_q <= work_d;
            mode_q <= mode_d;
        end
    end

endmodule
`default_nettype wire
